// File: rtl/alu_op_responder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_responder
// Brief    : Handshaked registered ALU with NZCV state and 2-entry skid output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_responder #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    input  logic          req_setf,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_out,
    output logic [3:0]    rsp_flags,
    output logic [3:0]    nzcv,
    output logic [CW-1:0] op_count
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_ORR = 3'b011;
    localparam logic [2:0] c_OP_EOR = 3'b100;
    localparam logic [2:0] c_OP_MOV = 3'b101;
    localparam logic [2:0] c_OP_CMP = 3'b110;
    localparam logic [2:0] c_OP_ADC = 3'b111;

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [3:0]    r_out_flags;
    logic          r_skid_valid;
    logic [W-1:0]  r_skid_data;
    logic [3:0]    r_skid_flags;
    logic [3:0]    r_nzcv;
    logic [CW-1:0] r_count;

    logic [W:0]    w_sum;
    logic [W-1:0]  w_res;
    logic          w_c;
    logic          w_v;
    logic [3:0]    w_flags;
    logic          w_accept;
    logic          w_respond;

    // Subtraction is A + ~B + 1 so bit W is directly the NOT-borrow carry.
    always_comb begin
        w_sum = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (req_op)
            c_OP_ADD, c_OP_ADC: begin
                w_sum = {1'b0, req_a} + {1'b0, req_b}
                      + {{W{1'b0}}, (req_op == c_OP_ADC) ? r_nzcv[1] : 1'b0};
                w_c   = w_sum[W];
                w_v   = (req_a[W-1] == req_b[W-1]) && (w_sum[W-1] != req_a[W-1]);
            end
            c_OP_SUB, c_OP_CMP: begin
                w_sum = {1'b0, req_a} + {1'b0, ~req_b} + {{W{1'b0}}, 1'b1};
                w_c   = w_sum[W];
                w_v   = (req_a[W-1] != req_b[W-1]) && (w_sum[W-1] != req_a[W-1]);
            end
            c_OP_AND: w_sum = {1'b0, req_a & req_b};
            c_OP_ORR: w_sum = {1'b0, req_a | req_b};
            c_OP_EOR: w_sum = {1'b0, req_a ^ req_b};
            c_OP_MOV: w_sum = {1'b0, req_b};
            default:  w_sum = '0;
        endcase
        w_res   = w_sum[W-1:0];
        w_flags = {w_res[W-1], (w_res == '0), w_c, w_v};
    end

    assign req_ready = ~r_skid_valid;
    assign w_accept  = req_valid && req_ready;
    assign w_respond = r_out_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_flags  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_flags <= '0;
            r_nzcv       <= '0;
            r_count      <= '0;
        end else begin
            if (w_accept && (req_setf || req_op == c_OP_CMP)) begin
                r_nzcv <= w_flags;
            end
            if (w_respond) begin
                r_count <= r_count + CW'(1);
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_flags  <= r_skid_flags;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_data  <= w_res;
                    r_out_flags <= w_flags;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // Output held by a stalled consumer: park the new entry in skid.
                if (r_out_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_res;
                    r_skid_flags <= w_flags;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_res;
                    r_out_flags <= w_flags;
                end
            end
        end
    end

    assign rsp_valid = r_out_valid;
    assign rsp_out   = r_out_data;
    assign rsp_flags = r_out_flags;
    assign nzcv      = r_nzcv;
    assign op_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_responder
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_responder;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_setf;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_out;
    logic [3:0]    rsp_flags;
    logic [3:0]    nzcv;
    logic [CW-1:0] op_count;

    alu_op_responder #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_setf  (req_setf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .nzcv      (nzcv),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
    } ent_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       setf;
        logic [7:0] res;
        logic [3:0] flg;
        logic [3:0] nz;
    } vec_t;

    ent_t q[$];
    logic [3:0] nzcv_m;
    int cnt_m;
    int total = 0;
    int bad   = 0;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions of each operation.
    function automatic ent_t ref_alu(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic cin);
        int ua, ub, sa, sb, r, sr;
        bit c, v;
        ent_t e;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 0; v = 0; r = 0;
        case (op)
            3'd0, 3'd7: begin
                r  = ua + ub + ((op == 3'd7) ? int'(cin) : 0);
                sr = sa + sb + ((op == 3'd7) ? int'(cin) : 0);
                c  = (r > 255);
                v  = (sr > 127) || (sr < -128);
            end
            3'd1, 3'd6: begin
                r  = ua - ub;
                sr = sa - sb;
                c  = (ua >= ub);
                v  = (sr > 127) || (sr < -128);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            default: r = ub;
        endcase
        e.res = 8'(r & 255);
        e.flg = {e.res[7], (e.res == 8'h00), c, v};
        return e;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic cyc(input bit rst, input bit v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit setf, input bit rr);
        bit acc, rsp;
        ent_t e;
        chk("rsp_valid", rsp_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("rsp_out", rsp_out, q[0].res);
            chk("rsp_flags", rsp_flags, q[0].flg);
        end
        chk("req_ready", req_ready, q.size() < 2);
        chk("nzcv", nzcv, nzcv_m);
        chk("op_count", op_count, cnt_m % 16);
        reset = rst; req_valid = v; req_op = op; req_a = a; req_b = b;
        req_setf = setf; rsp_ready = rr;
        acc = !rst && v && (q.size() < 2);
        rsp = !rst && (q.size() > 0) && rr;
        e = ref_alu(op, a, b, nzcv_m[1]);
        @(posedge clk); #1;
        if (rst) begin
            q.delete(); nzcv_m = 4'h0; cnt_m = 0;
        end else begin
            if (rsp) begin
                void'(q.pop_front());
                cnt_m++;
            end
            if (acc) begin
                q.push_back(e);
                if (setf || op == 3'd6) nzcv_m = e.flg;
            end
        end
    endtask

    task automatic idle(input bit rr);
        cyc(0, 0, 3'd0, 8'h00, 8'h00, 0, rr);
    endtask

    task automatic do_reset;
        reset = 1; req_valid = 0; rsp_ready = 0;
        req_op = 0; req_a = 0; req_b = 0; req_setf = 0;
        @(posedge clk); #1;
        q.delete(); nzcv_m = 4'h0; cnt_m = 0;
        reset = 0;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 4'b1001};
        tbl[1]  = '{3'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110, 4'b0110};
        tbl[2]  = '{3'd7, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000, 4'b0000};
        tbl[3]  = '{3'd6, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0110, 4'b0110};
        tbl[4]  = '{3'd1, 8'h03, 8'h05, 1'b0, 8'hFE, 4'b1000, 4'b0110};
        tbl[5]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 4'b0000};
        tbl[6]  = '{3'd3, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0100, 4'b0100};
        tbl[7]  = '{3'd4, 8'hAA, 8'hFF, 1'b0, 8'h55, 4'b0000, 4'b0100};
        tbl[8]  = '{3'd5, 8'h12, 8'h80, 1'b1, 8'h80, 4'b1000, 4'b1000};
        tbl[9]  = '{3'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 4'b0011};
        tbl[10] = '{3'd7, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1001, 4'b1001};
        tbl[11] = '{3'd0, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0111, 4'b0111};

        do_reset();
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_out", {rsp_out, rsp_flags, nzcv}, 16'h0000);

        // Back-to-back vectors with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].setf, 1);
            chk($sformatf("tbl%0d_res", i), rsp_out, tbl[i].res);
            chk($sformatf("tbl%0d_flags", i), rsp_flags, tbl[i].flg);
            chk($sformatf("tbl%0d_nzcv", i), nzcv, tbl[i].nz);
        end
        idle(1);

        // Backpressure: two accepted, third held off until the first drains.
        do_reset();
        cyc(0, 1, 3'd0, 8'h11, 8'h22, 0, 0);
        cyc(0, 1, 3'd1, 8'h50, 8'h10, 0, 0);
        chk("bp_ready_low", req_ready, 1'b0);
        cyc(0, 1, 3'd2, 8'hF0, 8'h3C, 0, 0);
        chk("bp_hold_out", rsp_out, 8'h33);
        cyc(0, 1, 3'd2, 8'hF0, 8'h3C, 0, 1);
        chk("bp_second", rsp_out, 8'h40);
        cyc(0, 1, 3'd2, 8'hF0, 8'h3C, 0, 1);
        idle(1);
        idle(1);
        idle(1);
        chk("bp_count", op_count, 4'd3);

        // Reset with both entries full and nzcv set.
        do_reset();
        cyc(0, 1, 3'd0, 8'h7F, 8'h01, 1, 0);
        cyc(0, 1, 3'd0, 8'h01, 8'h01, 0, 0);
        chk("full_nzcv", nzcv, 4'b1001);
        chk("full_ready", req_ready, 1'b0);
        cyc(1, 1, 3'd0, 8'h01, 8'h02, 1, 0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_nzcv", nzcv, 4'b0000);
        chk("rst_count", op_count, 4'd0);
        chk("rst_data", {rsp_out, rsp_flags}, 12'h000);
        cyc(0, 1, 3'd5, 8'h00, 8'h5A, 0, 1);
        chk("mov_res", {rsp_out, rsp_flags}, {8'h5A, 4'b0000});
        idle(1);

        // Counter wrap: 17 handshakes on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) cyc(0, 1, 3'd5, 8'h00, 8'(i), 0, 1);
        idle(1);
        chk("wrap_count", op_count, 4'd1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                3'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
